// File: rtl/iecdrv_rom_sched_if.sv
// Bus bundle between the drive CPUs, the shared ROM port and the slot scheduler.
// The scheduler sits on the slave side; the drive/ROM environment is the master.
interface iecdrv_rom_sched_if #(
    parameter int NDR = 4,
    parameter int AW  = 15,
    parameter int DW  = 8
);
    logic              ph2_f;
    logic [1:0]        rom_sz;
    logic              stdrom;
    logic [NDR*AW-1:0] drv_addr;
    logic [AW-1:0]     mem_a;
    logic              mem_rd;
    logic [DW-1:0]     mem_q;
    logic [NDR*DW-1:0] drv_data;
    logic [NDR-1:0]    drv_vld;
    logic              busy;
    logic              overrun;
    logic              ovr_clr;

    modport master (
        output ph2_f, rom_sz, stdrom, drv_addr, mem_q, ovr_clr,
        input  mem_a, mem_rd, drv_data, drv_vld, busy, overrun
    );

    modport slave (
        input  ph2_f, rom_sz, stdrom, drv_addr, mem_q, ovr_clr,
        output mem_a, mem_rd, drv_data, drv_vld, busy, overrun
    );
endinterface

// File: rtl/iecdrv_rom_sched.sv
// Round-robin time-slot scheduler sharing one synchronous drive ROM among NDR CPUs.
// Each ph2_f starts a round of one folded read per drive; results return by slot tag.
module iecdrv_rom_sched #(
    parameter int NDR   = 4,
    parameter int AW    = 15,
    parameter int DW    = 8,
    parameter int RDLAT = 1
) (
    input  logic                clk,
    input  logic                reset,
    iecdrv_rom_sched_if.slave   bus
);
    localparam int SW = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e                     state_q, state_d;
    logic [SW-1:0]              slot_q, slot_d;
    logic [1:0]                 sz_q, sz_d;
    logic                       std_q, std_d;
    logic                       iss;
    logic                       flush;
    logic                       pend;
    logic [AW-1:0]              addr_sel;
    logic [AW-1:0]              addr_fold;
    logic [AW-1:0]              mem_a_q;
    logic [RDLAT:0]             tv_q;
    logic [RDLAT:0][SW-1:0]     tid_q;
    logic [NDR-1:0][DW-1:0]     data_q;
    logic [NDR-1:0]             vld_q;
    logic                       busy_q;
    logic                       ovr_q;

    // Stages below the last one still hold reads whose data has not arrived.
    assign pend = |tv_q[RDLAT-1:0];

    always_comb begin
        addr_sel = '0;
        for (int k = 0; k < NDR; k++) begin
            if (slot_q == SW'(k)) addr_sel = bus.drv_addr[k*AW +: AW];
        end
    end

    always_comb begin
        addr_fold     = addr_sel;
        addr_fold[14] = addr_sel[14] & sz_q[1];
        addr_fold[13] = addr_sel[13] & (sz_q[0] | std_q);
    end

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        sz_d    = sz_q;
        std_d   = std_q;
        iss     = 1'b0;
        flush   = 1'b0;
        if (bus.ph2_f) begin
            flush   = (state_q != IDLE);
            state_d = ISSUE;
            slot_d  = '0;
            sz_d    = bus.rom_sz;
            std_d   = bus.stdrom;
        end else begin
            unique case (state_q)
                ISSUE: begin
                    iss = 1'b1;
                    if (slot_q == SW'(NDR-1)) state_d = DRAIN;
                    else                      slot_d  = slot_q + 1'b1;
                end
                DRAIN: begin
                    if (!pend) state_d = IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            slot_q  <= '0;
            sz_q    <= '0;
            std_q   <= 1'b0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            sz_q    <= sz_d;
            std_q   <= std_d;
            busy_q  <= (state_q != IDLE);
            if (flush)        ovr_q <= 1'b1;
            else if (bus.ovr_clr) ovr_q <= 1'b0;
        end
    end

    // A restart clears in-flight tags; the capture already at the last stage completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_a_q <= '0;
            tv_q    <= '0;
            tid_q   <= '0;
        end else begin
            if (iss) mem_a_q <= addr_fold;
            tv_q[0]  <= iss;
            tid_q[0] <= slot_q;
            for (int i = 1; i <= RDLAT; i++) begin
                tv_q[i]  <= tv_q[i-1] & ~flush;
                tid_q[i] <= tid_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
            vld_q  <= '0;
        end else begin
            for (int k = 0; k < NDR; k++) begin
                vld_q[k] <= tv_q[RDLAT] && (tid_q[RDLAT] == SW'(k));
                if (tv_q[RDLAT] && (tid_q[RDLAT] == SW'(k))) data_q[k] <= bus.mem_q;
            end
        end
    end

    assign bus.mem_a    = mem_a_q;
    assign bus.mem_rd   = tv_q[0];
    assign bus.drv_data = data_q;
    assign bus.drv_vld  = vld_q;
    assign bus.busy     = busy_q;
    assign bus.overrun  = ovr_q;
endmodule
